sr_latch_driver: RTL and testbench
==================================

// Module: sr_latch_driver
// PURPOSE
//  Synchronous initiator for the gated NAND SR latch: accepts set/reset/hold commands, sequences S/R setup,
//  C enable pulse and hold, then samples Q/Qbar after settling and returns a checked response.
//  Sits between system-level control logic and a discrete/gate-level latch instance; drives the latch's C,S,R.
// PARAMETERS
//  SETUP_CYC   1  cycles S/R stable before C rises (>=1)
//  PULSE_CYC   2  cycles C held high (>=1)
//  HOLD_CYC    1  cycles S/R held after C falls (>=1)
//  SETTLE_CYC  2  cycles after HOLD before Q/Qbar sampled (>=2, covers 2-FF sync)
//  CNT_W       4  phase counter width; every *_CYC <= 2**CNT_W
// PORTS
//  clk         in   1  single clock, all state rising-edge
//  rst         in   1  asynchronous, active-high reset
//  cmd_valid   in   1  command offered
//  cmd_ready   out  1  driver idle, command accepted on valid&ready
//  cmd_op      in   2  00 hold (pulse C, S=R=0), 01 set, 10 reset, 11 illegal
//  rsp_valid   out  1  response available
//  rsp_ready   in   1  response consumed on valid&ready
//  rsp_q       out  1  synchronized Q sampled at end of SETTLE
//  rsp_err     out  2  00 ok, 01 Q != expected, 10 illegal op, 11 Q==Qbar (invalid)
//  latch_c     out  1  latch enable (C)
//  latch_s     out  1  latch S
//  latch_r     out  1  latch R
//  latch_q     in   1  latch Q (asynchronous to clk)
//  latch_qbar  in   1  latch Qbar (asynchronous to clk)
// BEHAVIOUR
//  - Reset (async): state IDLE; cmd_ready=1 after release; rsp_valid=0, rsp_q=0, rsp_err=00;
//    latch_c/s/r=0 immediately; expected value invalid (exp_vld=0); sync FFs cleared. Latch keeps its state.
//  - FSM: IDLE -> SETUP -> PULSE -> HOLD -> SETTLE -> RESP -> IDLE. Counter loads *_CYC-1 on entry,
//    state advances when counter reaches 0. Op 11: IDLE -> RESP directly, rsp_err=10, no latch activity.
//  - cmd_ready = (state==IDLE). cmd_op captured on acceptance edge k; ignored otherwise.
//  - Outputs registered, glitch-free: latch_s=(op==01), latch_r=(op==10) in SETUP/PULSE/HOLD, else 0;
//    latch_c=1 only in PULSE. S and R never both 1.
//  - Latency: accept at edge k -> rsp_valid rises at edge k+SETUP+PULSE+HOLD+SETTLE+1 (defaults: k+7);
//    illegal op -> k+1.
//  - Q/Qbar pass through 2-FF synchronizer; sampled on last SETTLE cycle into rsp_q.
//  - Check priority: q==qbar -> 11; else exp_vld && q!=exp -> 01; else 00.
//  - Expected update on leaving SETTLE: set -> exp=1,exp_vld=1; reset -> exp=0,exp_vld=1; hold unchanged.
//    Invalid (11) response clears exp_vld.
//  - RESP: rsp_valid=1, rsp_q/rsp_err stable until rsp_valid&rsp_ready; then IDLE next edge, cmd_ready=1.
//    No command accepted while response pending (no overlap).
//  - Reset mid-operation aborts instantly: C drops same cycle, partial pulse not reported.
// STRUCTURE
//  - Package sr_drv_pkg: state encodings, OP_HOLD/OP_SET/OP_RST/OP_ILL, ERR_OK/ERR_MIS/ERR_ILL/ERR_INV.
//  - Sub-module sync2 (2-FF synchronizer, async-reset to 0), instantiated twice for latch_q/latch_qbar.
//  - Top: FSM + phase counter + op/expected registers + response registers.
// TESTING (bench uses behavioural gated SR latch model on latch_c/s/r)
//  1 rst, op=01 accepted edge k -> latch_s=1 for 4 cycles, latch_c=1 exactly 2 cycles, rsp_valid at k+7, rsp_q=1, err=00.
//  2 after 1, op=10 -> rsp_q=0 err=00; then force model Q=0,Qbar=1, op=01 -> rsp_q=0 err=01.
//  3 op=11 at edge k -> latch_c/s/r stay 0, rsp_valid at k+1, err=10, exp unchanged.
//  4 rsp_ready=0 for 5 cycles -> rsp_valid, rsp_q, rsp_err stable, cmd_ready=0; rsp_ready=1 -> cmd_ready=1 next edge.
//  5 force Q=Qbar=1, op=00 -> err=11; next op=00 with Q=1,Qbar=0 -> err=00 (exp_vld cleared).
//  6 rst pulse during PULSE -> latch_c/s/r=0 before next edge, no rsp_valid; post-reset op=00 -> err=00 (no check).

Source files
------------

// File: rtl/sr_latch_driver_pkg.sv
// Shared encodings for the gated SR latch driver: FSM states, command ops and
// response error codes, plus the response classification helper.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_SETTLE,
    ST_RESP
  } drvState_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SET  = 2'b01,
    OP_RST  = 2'b10,
    OP_ILL  = 2'b11
  } drvOp_t;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_MIS = 2'b01,
    ERR_ILL = 2'b10,
    ERR_INV = 2'b11
  } drvErr_t;

  // A latch showing Q==Qbar is invalid regardless of what we expected.
  function automatic drvErr_t classifyResult(input logic q, input logic qb,
                                             input logic expVld, input logic expQ);
    if (q == qb)
      return ERR_INV;
    else if (expVld && (q != expQ))
      return ERR_MIS;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for bringing the asynchronous latch outputs into the
// clk domain; clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Synchronous initiator for a gated NAND SR latch: sequences S/R setup, the C
// pulse and hold, then samples the synchronized Q/Qbar and returns a checked response.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic [1:0] rsp_err,
  output logic       latch_c,
  output logic       latch_s,
  output logic       latch_r,
  input  logic       latch_q,
  input  logic       latch_qbar
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  drvState_t        state;
  logic [CNT_W-1:0] cnt;
  drvOp_t           opReg;
  logic             expQ;
  logic             expVld;
  logic             cmdReady;
  logic             rspValid;
  logic             rspQ;
  drvErr_t          rspErr;
  logic             latchC;
  logic             latchS;
  logic             latchR;

  logic             qSync;
  logic             qbSync;
  logic             nextExpQ;
  logic             nextExpVld;
  drvErr_t          settleErr;
  logic             phaseDone;

  sync2 uSyncQ (
    .clk (clk),
    .rst (rst),
    .d   (latch_q),
    .q   (qSync)
  );

  sync2 uSyncQb (
    .clk (clk),
    .rst (rst),
    .d   (latch_qbar),
    .q   (qbSync)
  );

  assign phaseDone = (cnt == '0);

  // The response is judged against the value this op should leave behind,
  // so set/reset update the expectation before the comparison.
  always_comb begin
    nextExpQ   = expQ;
    nextExpVld = expVld;
    case (opReg)
      OP_SET: begin
        nextExpQ   = 1'b1;
        nextExpVld = 1'b1;
      end
      OP_RST: begin
        nextExpQ   = 1'b0;
        nextExpVld = 1'b1;
      end
      default: ;
    endcase
    settleErr = classifyResult(qSync, qbSync, nextExpVld, nextExpQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      opReg    <= OP_HOLD;
      expQ     <= 1'b0;
      expVld   <= 1'b0;
      cmdReady <= 1'b1;
      rspValid <= 1'b0;
      rspQ     <= 1'b0;
      rspErr   <= ERR_OK;
      latchC   <= 1'b0;
      latchS   <= 1'b0;
      latchR   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            opReg    <= drvOp_t'(cmd_op);
            cmdReady <= 1'b0;
            if (drvOp_t'(cmd_op) == OP_ILL) begin
              state  <= ST_RESP;
              rspQ   <= 1'b0;
              rspErr <= ERR_ILL;
            end else begin
              state  <= ST_SETUP;
              cnt    <= SETUP_LD;
              latchS <= (drvOp_t'(cmd_op) == OP_SET);
              latchR <= (drvOp_t'(cmd_op) == OP_RST);
            end
          end
        end

        ST_SETUP: begin
          if (phaseDone) begin
            state  <= ST_PULSE;
            cnt    <= PULSE_LD;
            latchC <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_PULSE: begin
          if (phaseDone) begin
            state  <= ST_HOLD;
            cnt    <= HOLD_LD;
            latchC <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          if (phaseDone) begin
            state  <= ST_SETTLE;
            cnt    <= SETTLE_LD;
            latchS <= 1'b0;
            latchR <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SETTLE: begin
          if (phaseDone) begin
            state  <= ST_RESP;
            rspQ   <= qSync;
            rspErr <= settleErr;
            expQ   <= nextExpQ;
            expVld <= (settleErr == ERR_INV) ? 1'b0 : nextExpVld;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // First RESP cycle raises rsp_valid; the handshake is only honoured
        // once it is visible.
        ST_RESP: begin
          if (!rspValid) begin
            rspValid <= 1'b1;
          end else if (rsp_ready) begin
            rspValid <= 1'b0;
            state    <= ST_IDLE;
            cmdReady <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          cmdReady <= 1'b1;
          rspValid <= 1'b0;
          latchC   <= 1'b0;
          latchS   <= 1'b0;
          latchR   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmdReady;
  assign rsp_valid = rspValid;
  assign rsp_q     = rspQ;
  assign rsp_err   = rspErr;
  assign latch_c   = latchC;
  assign latch_s   = latchS;
  assign latch_r   = latchR;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver with a behavioural gated SR latch on C/S/R that can
// be forced to stuck Q/Qbar values.
module tb_sr_latch_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_q;
  logic [1:0] rsp_err;
  logic       latch_c;
  logic       latch_s;
  logic       latch_r;
  logic       latch_q;
  logic       latch_qbar;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .SETUP_CYC  (1),
    .PULSE_CYC  (2),
    .HOLD_CYC   (1),
    .SETTLE_CYC (2),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_q      (rsp_q),
    .rsp_err    (rsp_err),
    .latch_c    (latch_c),
    .latch_s    (latch_s),
    .latch_r    (latch_r),
    .latch_q    (latch_q),
    .latch_qbar (latch_qbar)
  );

  // Gated SR latch; while stuck it ignores C and shows the forced outputs.
  logic modelQ, modelQb;
  logic stuck = 1'b0, forceQ = 1'b0, forceQb = 1'b1;
  initial begin
    modelQ  = 1'b0;
    modelQb = 1'b1;
    forever begin
      @(latch_c or latch_s or latch_r);
      if (latch_c && !stuck) begin
        if (latch_s && !latch_r) begin
          modelQ  = 1'b1;
          modelQb = 1'b0;
        end else if (latch_r && !latch_s) begin
          modelQ  = 1'b0;
          modelQb = 1'b1;
        end
      end
    end
  end
  assign latch_q    = stuck ? forceQ  : modelQ;
  assign latch_qbar = stuck ? forceQb : modelQb;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       q;
    logic [1:0] err;
    int         lat;
    int         sCnt;
    int         cCnt;
    int         rCnt;
  } rsp_t;

  rsp_t sb[$];

  typedef struct {
    logic [1:0] op;
    logic       stk;
    logic       fq;
    logic       fqb;
    logic       q;
    logic [1:0] err;
  } vec_t;

  // Issue one command, push its expected response, then compare once the
  // response appears; stall holds rsp_ready low for that many extra cycles.
  task automatic runOp(input logic [1:0] op, input logic q, input logic [1:0] err,
                       input int stall);
    rsp_t e, got;
    int   n, sN, cN, rN, both;
    bit   seen;
    @(negedge clk);
    check("cmd_ready before command", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    e.q    = q;
    e.err  = err;
    e.lat  = (op == 2'b11) ? 1 : 7;
    e.sCnt = (op == 2'b01) ? 4 : 0;
    e.rCnt = (op == 2'b10) ? 4 : 0;
    e.cCnt = (op == 2'b11) ? 0 : 2;
    sb.push_back(e);
    @(posedge clk);
    sN = 0; cN = 0; rN = 0; both = 0; seen = 1'b0; n = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (i == 0) cmd_valid = 1'b0;
      if (rsp_valid) begin
        seen = 1'b1;
        n    = i;
        break;
      end
      sN += int'(latch_s);
      cN += int'(latch_c);
      rN += int'(latch_r);
      both += int'(latch_s & latch_r);
      @(posedge clk);
    end
    got = sb.pop_front();
    check("rsp_valid within bound", rsp_valid, 1);
    check("rsp latency", n, got.lat);
    check("latch_s high cycles", sN, got.sCnt);
    check("latch_c high cycles", cN, got.cCnt);
    check("latch_r high cycles", rN, got.rCnt);
    check("S and R overlap cycles", both, 0);
    check("rsp_q", rsp_q, got.q);
    check("rsp_err", rsp_err, got.err);
    if (seen) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        check("stall rsp_valid", rsp_valid, 1);
        check("stall rsp_q", rsp_q, got.q);
        check("stall rsp_err", rsp_err, got.err);
        check("stall cmd_ready", cmd_ready, 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("rsp_valid after handshake", rsp_valid, 0);
      check("cmd_ready after handshake", cmd_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   n, vCnt;

    vecs[0] = '{op: 2'b01, stk: 1'b0, fq: 1'b0, fqb: 1'b0, q: 1'b1, err: 2'b00};
    vecs[1] = '{op: 2'b10, stk: 1'b0, fq: 1'b0, fqb: 1'b0, q: 1'b0, err: 2'b00};
    vecs[2] = '{op: 2'b01, stk: 1'b1, fq: 1'b0, fqb: 1'b1, q: 1'b0, err: 2'b01};
    vecs[3] = '{op: 2'b11, stk: 1'b0, fq: 1'b0, fqb: 1'b0, q: 1'b0, err: 2'b10};
    vecs[4] = '{op: 2'b00, stk: 1'b0, fq: 1'b0, fqb: 1'b0, q: 1'b0, err: 2'b01};
    vecs[5] = '{op: 2'b10, stk: 1'b0, fq: 1'b0, fqb: 1'b0, q: 1'b0, err: 2'b00};
    vecs[6] = '{op: 2'b00, stk: 1'b1, fq: 1'b1, fqb: 1'b1, q: 1'b1, err: 2'b11};
    vecs[7] = '{op: 2'b00, stk: 1'b1, fq: 1'b1, fqb: 1'b0, q: 1'b1, err: 2'b00};
    vecs[8] = '{op: 2'b01, stk: 1'b0, fq: 1'b0, fqb: 1'b0, q: 1'b1, err: 2'b00};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    rsp_ready = 1'b0;
    #1;
    check("reset latch_c", latch_c, 0);
    check("reset latch_s", latch_s, 0);
    check("reset latch_r", latch_r, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_q", rsp_q, 0);
    check("reset rsp_err", rsp_err, 0);

    for (int i = 0; i < 9; i++) begin
      stuck   = vecs[i].stk;
      forceQ  = vecs[i].fq;
      forceQb = vecs[i].fqb;
      runOp(vecs[i].op, vecs[i].q, vecs[i].err, 0);
    end
    stuck = 1'b0;

    // Response back-pressure: everything must hold while rsp_ready is low.
    runOp(2'b01, 1'b1, 2'b00, 5);

    // Reset in the middle of a reset-op pulse: C/S/R drop before the next
    // edge, nothing is reported, and the expectation is forgotten.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (latch_c) break;
      @(posedge clk);
      #1;
    end
    check("reached pulse before abort", latch_c, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort latch_c", latch_c, 0);
    check("abort latch_s", latch_s, 0);
    check("abort latch_r", latch_r, 0);
    check("abort rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst  = 1'b0;
    vCnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      vCnt += int'(rsp_valid);
    end
    check("no response after abort", vCnt, 0);
    check("cmd_ready after abort", cmd_ready, 1);
    runOp(2'b00, 1'b0, 2'b00, 0);

    n = sb.size();
    check("scoreboard drained", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
